// File: rtl/dbd_pkg.sv
// Shared types and constants for the dynamic-backlight-dimming LUT writer.
// Used by dbd_lut_writer and dbd_serial_div.
package dbd_pkg;

    localparam int NUM_BITS = 17;
    localparam int DIV_ITER = 17;
    localparam int LUT_MAX  = 255;
    localparam int CNT_BITS = $clog2(DIV_ITER + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        WRITE,
        DONE
    } lut_state_e;

endpackage

// File: rtl/dbd_serial_div.sv
// Restoring divider: one quotient bit per clock, fixed DIV_ITER-cycle latency.
// ready is high during the final iteration; quotient is valid from the next cycle until the next start.
module dbd_serial_div
    import dbd_pkg::*;
#(
    parameter int NUM_W = NUM_BITS,
    parameter int DEN_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic [NUM_W-1:0] quotient,
    output logic             ready
);

    logic [NUM_W-1:0]    quo_reg;
    logic [DEN_W-1:0]    rem_reg;
    logic [DEN_W-1:0]    den_reg;
    logic [CNT_BITS-1:0] cnt_reg;
    logic [DEN_W:0]      trial;
    logic                take;
    logic [DEN_W-1:0]    rem_next;

    // The dividend register doubles as the quotient shift register.
    always_comb begin
        trial    = {rem_reg, quo_reg[NUM_W-1]};
        take     = (trial >= {1'b0, den_reg});
        rem_next = take ? DEN_W'(trial - {1'b0, den_reg}) : trial[DEN_W-1:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quo_reg <= '0;
            rem_reg <= '0;
            den_reg <= '0;
            cnt_reg <= '0;
        end else if (start) begin
            quo_reg <= dividend;
            rem_reg <= '0;
            den_reg <= divisor;
            cnt_reg <= CNT_BITS'(DIV_ITER);
        end else if (cnt_reg != '0) begin
            quo_reg <= {quo_reg[NUM_W-2:0], take};
            rem_reg <= rem_next;
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign quotient = quo_reg;
    assign ready    = (cnt_reg == CNT_BITS'(1));

endmodule

// File: rtl/dbd_lut_writer.sv
// Per-frame compensation-LUT generator: entry i = min((i*255 + bl/2) / bl, 255), streamed as write strobes.
// Optional saturation counter output enabled by defining DBD_LUT_SAT_COUNT_EN.
module dbd_lut_writer
    import dbd_pkg::*;
#(
    parameter int LUT_DEPTH = 360,
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] bl_level,
    output logic                 lut_we,
    output logic [ADDR_BITS-1:0] lut_addr,
    output logic [DATA_BITS-1:0] lut_data,
    output logic                 busy,
    output logic                 done
`ifdef DBD_LUT_SAT_COUNT_EN
    ,
    output logic [ADDR_BITS-1:0] sat_count
`endif
);

    lut_state_e           state_reg, state_next;
    logic [DATA_BITS-1:0] bl_reg;
    logic [ADDR_BITS-1:0] idx_reg;
    logic [ADDR_BITS-1:0] addr_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic [NUM_BITS-1:0]  numerator;
    logic [NUM_BITS-1:0]  quotient;
    logic [DATA_BITS-1:0] clamped;
    logic                 div_start;
    logic                 div_ready;
    logic                 saturated;
    logic                 last_entry;
    logic                 accept;

    assign accept     = (state_reg == IDLE) && start;
    assign last_entry = (idx_reg == ADDR_BITS'(LUT_DEPTH - 1));
    assign numerator  = NUM_BITS'(idx_reg) * NUM_BITS'(LUT_MAX) + NUM_BITS'(bl_reg >> 1);
    // A zero divisor yields an all-ones quotient anyway; the explicit test keeps the intent obvious.
    assign saturated  = (bl_reg == '0) || (quotient > NUM_BITS'(LUT_MAX));
    assign clamped    = saturated ? DATA_BITS'(LUT_MAX) : quotient[DATA_BITS-1:0];

    dbd_serial_div #(
        .NUM_W (NUM_BITS),
        .DEN_W (DATA_BITS)
    ) u_div (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (numerator),
        .divisor  (bl_reg),
        .quotient (quotient),
        .ready    (div_ready)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        div_start  = 1'b0;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD: begin
                div_start  = 1'b1;
                state_next = DIV;
            end
            DIV:     if (div_ready) state_next = WRITE;
            WRITE:   state_next = last_entry ? DONE : LOAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bl_reg   <= '0;
            idx_reg  <= '0;
            addr_reg <= '0;
            data_reg <= '0;
        end else begin
            if (accept) begin
                bl_reg  <= bl_level;
                idx_reg <= '0;
            end
            if (state_reg == WRITE) begin
                addr_reg <= idx_reg;
                data_reg <= clamped;
                if (!last_entry) idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    // Strobe/status outputs decode the state directly, so reset drops them without waiting for a clock.
    // Address/data show the live entry during WRITE and the last written pair otherwise.
    assign lut_we   = (state_reg == WRITE);
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign lut_addr = lut_we ? idx_reg : addr_reg;
    assign lut_data = lut_we ? clamped : data_reg;

`ifdef DBD_LUT_SAT_COUNT_EN
    logic [ADDR_BITS-1:0] sat_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sat_reg <= '0;
        end else if (accept) begin
            sat_reg <= '0;
        end else if ((state_reg == WRITE) && saturated) begin
            sat_reg <= sat_reg + 1'b1;
        end
    end

    assign sat_count = sat_reg;
`endif

endmodule

// File: tb/tb_dbd_lut_writer.sv
// Self-checking bench for dbd_lut_writer against an arithmetic model of the LUT curve and build timing.
// Saturation-count checks are active when DBD_LUT_SAT_COUNT_EN is defined.
module tb_dbd_lut_writer;

    localparam int LUT_DEPTH = 360;
    localparam int ADDR_BITS = 9;
    localparam int DATA_BITS = 8;
    localparam int BUDGET    = 19 * LUT_DEPTH + 100;

    logic                 clock    = 1'b0;
    logic                 reset_n  = 1'b0;
    logic                 start    = 1'b0;
    logic [DATA_BITS-1:0] bl_level = '0;
    logic                 lut_we;
    logic [ADDR_BITS-1:0] lut_addr;
    logic [DATA_BITS-1:0] lut_data;
    logic                 busy;
    logic                 done;
`ifdef DBD_LUT_SAT_COUNT_EN
    logic [ADDR_BITS-1:0] sat_count;
`endif

    int compared   = 0;
    int mismatched = 0;
    int got_data [LUT_DEPTH];

    dbd_lut_writer #(
        .LUT_DEPTH (LUT_DEPTH),
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .bl_level  (bl_level),
        .lut_we    (lut_we),
        .lut_addr  (lut_addr),
        .lut_data  (lut_data),
        .busy      (busy),
        .done      (done)
`ifdef DBD_LUT_SAT_COUNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic int raw_entry(int i, int bl);
        return (i * 255 + bl / 2) / bl;
    endfunction

    function automatic int model_entry(int i, int bl);
        if (bl == 0) return 255;
        return (raw_entry(i, bl) > 255) ? 255 : raw_entry(i, bl);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one build from a start pulse; optionally pulses a second start at restart_at
    // or pulls reset at abort_at (cycle numbers counted from the edge that samples start).
    task automatic run_build(input int bl, input int restart_at, input int abort_at);
        int  n_wr;
        int  done_cyc;
        int  sat_exp;
        bit  aborted;
        n_wr     = 0;
        done_cyc = -1;
        sat_exp  = 0;
        aborted  = 1'b0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (bl == 0 || raw_entry(i, bl) > 255) sat_exp++;
            got_data[i] = -1;
        end
        start    = 1'b1;
        bl_level = DATA_BITS'(bl);
        @(posedge clock); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (cyc == abort_at) begin
                chk("pre_abort_we", lut_we, 1);
                reset_n = 1'b0;
                #1;
                chk("abort_we", lut_we, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                aborted = 1'b1;
                break;
            end
            chk($sformatf("busy_c%0d", cyc), busy, 1);
            if (lut_we) begin
                chk($sformatf("addr_w%0d", n_wr), lut_addr, n_wr);
                chk($sformatf("data_w%0d", n_wr), lut_data, model_entry(n_wr, bl));
                chk($sformatf("wcyc_w%0d", n_wr), cyc, 19 * n_wr + 18);
                if (int'(lut_addr) < LUT_DEPTH) got_data[lut_addr] = int'(lut_data);
                n_wr++;
            end else if (n_wr > 0) begin
                chk($sformatf("hold_addr_c%0d", cyc), lut_addr, n_wr - 1);
                chk($sformatf("hold_data_c%0d", cyc), lut_data, model_entry(n_wr - 1, bl));
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            bl_level = DATA_BITS'($urandom);
            if (cyc == restart_at) begin
                start    = 1'b1;
                bl_level = 8'd64;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
        if (aborted) begin
            @(posedge clock); #1;
            chk("in_reset_we", lut_we, 0);
            reset_n = 1'b1;
            #1;
            chk("post_reset_busy", busy, 0);
            chk("post_reset_addr", lut_addr, 0);
            chk("post_reset_data", lut_data, 0);
        end else begin
            chk($sformatf("done_cycle_bl%0d", bl), done_cyc, 19 * LUT_DEPTH);
            chk($sformatf("write_count_bl%0d", bl), n_wr, LUT_DEPTH);
`ifdef DBD_LUT_SAT_COUNT_EN
            chk($sformatf("sat_count_bl%0d", bl), sat_count, sat_exp);
`endif
            @(posedge clock); #1;
            chk("after_done_done", done, 0);
            chk("after_done_busy", busy, 0);
            chk("after_done_we", lut_we, 0);
`ifdef DBD_LUT_SAT_COUNT_EN
            chk("sat_count_stable", sat_count, sat_exp);
`endif
        end
    endtask

    initial begin
        int bl_r;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_we", lut_we, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_addr", lut_addr, 0);
        chk("reset_data", lut_data, 0);
`ifdef DBD_LUT_SAT_COUNT_EN
        chk("reset_sat", sat_count, 0);
`endif
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("idle_we", lut_we, 0);

        run_build(255, -1, -1);
        chk("bl255_e100", got_data[100], 100);
        chk("bl255_e255", got_data[255], 255);
        chk("bl255_e300", got_data[300], 255);

        run_build(128, -1, -1);
        chk("bl128_e0", got_data[0], 0);
        chk("bl128_e100", got_data[100], 199);
        chk("bl128_e128", got_data[128], 255);
        chk("bl128_e129", got_data[129], 255);

        run_build(0, -1, -1);
        chk("bl0_e359", got_data[359], 255);

        bl_r = int'($urandom_range(65, 255));
        run_build(bl_r, 500, -1);

        bl_r = int'($urandom_range(1, 255));
        run_build(bl_r, -1, 19 * 52 + 18);

        run_build(200, -1, -1);
        chk("bl200_e50", got_data[50], 64);

        bl_r = int'($urandom_range(1, 255));
        run_build(bl_r, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
